// File: rtl/pe_ctrl_pkg.sv
// Shared types for the unary-rate PE array tile sequencer: FSM states, the
// control bundle driven into the corner PE, and its per-state decode.
package pe_ctrl_pkg;

  localparam int IWIDTH_DEF = 16;
  localparam int KWIDTH_DEF = 16;
  localparam int DWIDTH_DEF = 8;

  typedef enum logic [2:0] {
    IDLE   = 3'd0,
    WLOAD  = 3'd1,
    IFETCH = 3'd2,
    MAC    = 3'd3,
    DRAIN  = 3'd4,
    DONE   = 3'd5,
    CLR    = 3'd6
  } state_t;

  typedef struct packed {
    logic en_i;
    logic clr_i;
    logic en_w;
    logic clr_w;
    logic en_o;
    logic clr_o;
    logic mac_done;
  } ctrl_t;

  localparam ctrl_t CTRL_IDLE = '0;

  // mac_done depends on counters as well as state, so the caller fills it in.
  function automatic ctrl_t ctrl_decode(state_t s);
    ctrl_t c;
    c = CTRL_IDLE;
    case (s)
      WLOAD:   begin c.en_w = 1'b1; c.clr_o = 1'b1; end
      IFETCH:  c.en_i = 1'b1;
      MAC:     c.en_o = 1'b1;
      DONE:    begin c.clr_i = 1'b1; c.clr_w = 1'b1; end
      CLR:     begin c.clr_i = 1'b1; c.clr_w = 1'b1; c.clr_o = 1'b1; end
      default: c = CTRL_IDLE;
    endcase
    return c;
  endfunction

endpackage

// File: rtl/pe_ctrl_cnt.sv
// Up-counter with synchronous clear, increment and terminal-count compare.
// LOOKAHEAD=1 compares the value the counter will hold after this edge.
module pe_ctrl_cnt #(
  parameter int W         = 8,
  parameter bit LOOKAHEAD = 1'b0
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr,
  input  logic         inc,
  input  logic [W-1:0] tc_val,
  output logic         tc
);

  logic [W-1:0] cnt_q;
  logic [W-1:0] cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (clr) begin
      cnt_d = '0;
    end else if (inc) begin
      cnt_d = cnt_q + 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tc = LOOKAHEAD ? (cnt_d == tc_val) : (cnt_q == tc_val);

endmodule

// File: rtl/pe_ctrl_unary.sv
// Tile sequencer for the unary-rate systolic PE array: weight load, K ifm
// fetch + L-cycle MAC steps, skew drain, done. All outputs are registered.
module pe_ctrl_unary
  import pe_ctrl_pkg::*;
#(
  parameter int IWIDTH = IWIDTH_DEF,
  parameter int KWIDTH = KWIDTH_DEF,
  parameter int DWIDTH = DWIDTH_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              start,
  input  logic              abort,
  input  logic [IWIDTH-2:0] cfg_mac,
  input  logic [KWIDTH-1:0] cfg_k,
  input  logic [DWIDTH-1:0] cfg_drain,
  output logic              busy,
  output logic              done,
  output logic              ifm_req,
  output logic              en_i,
  output logic              clr_i,
  output logic              en_w,
  output logic              clr_w,
  output logic              en_o,
  output logic              clr_o,
  output logic              mac_done,
  output logic [2:0]        dbg_state
);

  // start is a level sampled only in IDLE with no ready; busy low means the
  // next start will be taken. abort is honoured in every non-IDLE state.
  state_t state_q, state_d;
  logic [IWIDTH-2:0] cfg_mac_q, cfg_mac_d;
  logic [KWIDTH-1:0] cfg_k_q, cfg_k_d;
  logic [DWIDTH-1:0] cfg_drain_q, cfg_drain_d;
  ctrl_t ctrl_q, ctrl_d;
  logic busy_q, busy_d, done_q, done_d, ifm_req_q, ifm_req_d;
  logic cyc_last_q, cyc_last_d;
  logic cyc_tc, k_tc, drain_tc;
  logic accept;

  logic [IWIDTH-2:0] mac_tc_val;
  logic [KWIDTH-1:0] k_tc_val;
  logic [DWIDTH-1:0] drain_tc_val;

  // cfg_mac==0 wraps to all-ones, giving the full 2^(IWIDTH-1) cycle MAC.
  assign mac_tc_val   = cfg_mac_q - 1'b1;
  assign k_tc_val     = (cfg_k_q == '0) ? '0 : cfg_k_q - 1'b1;
  assign drain_tc_val = cfg_drain_q - 1'b1;

  assign accept = (state_q == IDLE) && start && !abort;

  pe_ctrl_cnt #(.W(IWIDTH-1), .LOOKAHEAD(1'b1)) u_cyc_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state_q == IFETCH),
    .inc    (state_q == MAC),
    .tc_val (mac_tc_val),
    .tc     (cyc_tc)
  );

  pe_ctrl_cnt #(.W(KWIDTH), .LOOKAHEAD(1'b0)) u_k_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state_q == WLOAD),
    .inc    ((state_q == MAC) && cyc_last_q && !k_tc),
    .tc_val (k_tc_val),
    .tc     (k_tc)
  );

  pe_ctrl_cnt #(.W(DWIDTH), .LOOKAHEAD(1'b0)) u_drain_cnt (
    .clk    (clk),
    .rst_n  (rst_n),
    .clr    (state_q != DRAIN),
    .inc    (state_q == DRAIN),
    .tc_val (drain_tc_val),
    .tc     (drain_tc)
  );

  always_comb begin
    state_d     = state_q;
    cfg_mac_d   = cfg_mac_q;
    cfg_k_d     = cfg_k_q;
    cfg_drain_d = cfg_drain_q;
    if (accept) begin
      cfg_mac_d   = cfg_mac;
      cfg_k_d     = cfg_k;
      cfg_drain_d = cfg_drain;
    end
    case (state_q)
      IDLE:    if (accept) state_d = WLOAD;
      WLOAD:   state_d = IFETCH;
      IFETCH:  state_d = MAC;
      MAC: begin
        if (cyc_last_q) begin
          if (!k_tc)                    state_d = IFETCH;
          else if (cfg_drain_q == '0)   state_d = DONE;
          else                          state_d = DRAIN;
        end
      end
      DRAIN:   if (drain_tc) state_d = DONE;
      DONE:    state_d = IDLE;
      CLR:     state_d = IDLE;
      default: state_d = IDLE;
    endcase
    if (abort && (state_q != IDLE)) begin
      state_d = CLR;
    end
  end

  // Outputs are decoded from the next state, so they line up with the state
  // they describe; cyc_tc looks ahead to the counter value of that state.
  always_comb begin
    ctrl_d          = ctrl_decode(state_d);
    ctrl_d.mac_done = (state_d == MAC) && cyc_tc && k_tc;
    busy_d          = (state_d != IDLE);
    done_d          = (state_d == DONE);
    ifm_req_d       = (state_d == IFETCH);
    cyc_last_d      = cyc_tc;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      cfg_mac_q   <= '0;
      cfg_k_q     <= '0;
      cfg_drain_q <= '0;
      ctrl_q      <= CTRL_IDLE;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      ifm_req_q   <= 1'b0;
      cyc_last_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      cfg_mac_q   <= cfg_mac_d;
      cfg_k_q     <= cfg_k_d;
      cfg_drain_q <= cfg_drain_d;
      ctrl_q      <= ctrl_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      ifm_req_q   <= ifm_req_d;
      cyc_last_q  <= cyc_last_d;
    end
  end

  assign busy      = busy_q;
  assign done      = done_q;
  assign ifm_req   = ifm_req_q;
  assign en_i      = ctrl_q.en_i;
  assign clr_i     = ctrl_q.clr_i;
  assign en_w      = ctrl_q.en_w;
  assign clr_w     = ctrl_q.clr_w;
  assign en_o      = ctrl_q.en_o;
  assign clr_o     = ctrl_q.clr_o;
  assign mac_done  = ctrl_q.mac_done;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_pe_ctrl_unary.sv
// Self-checking bench for pe_ctrl_unary: a per-cycle expected output trace is
// built from the tile rules (load, K x (fetch + L MAC), D drain, done).
module tb_pe_ctrl_unary;

  logic        clk;
  logic        rst_n;
  logic        start;
  logic        abort;
  logic [14:0] cfg_mac;
  logic [15:0] cfg_k;
  logic [7:0]  cfg_drain;
  logic        busy, done, ifm_req, en_i, clr_i, en_w, clr_w, en_o, clr_o, mac_done;
  logic [2:0]  dbg_state;
  logic [9:0]  obs;

  int n_tests;
  int n_fail;

  // {busy, done, ifm_req, en_i, clr_i, en_w, clr_w, en_o, clr_o, mac_done}
  localparam logic [9:0] V_IDLE  = 10'b0_0_0_0_0_0_0_0_0_0;
  localparam logic [9:0] V_WLOAD = 10'b1_0_0_0_0_1_0_0_1_0;
  localparam logic [9:0] V_IF    = 10'b1_0_1_1_0_0_0_0_0_0;
  localparam logic [9:0] V_MAC   = 10'b1_0_0_0_0_0_0_1_0_0;
  localparam logic [9:0] V_DRAIN = 10'b1_0_0_0_0_0_0_0_0_0;
  localparam logic [9:0] V_DONE  = 10'b1_1_0_0_1_0_1_0_0_0;
  localparam logic [9:0] V_CLR   = 10'b1_0_0_0_1_0_1_0_1_0;

  assign obs = {busy, done, ifm_req, en_i, clr_i, en_w, clr_w, en_o, clr_o, mac_done};

  pe_ctrl_unary dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .start     (start),
    .abort     (abort),
    .cfg_mac   (cfg_mac),
    .cfg_k     (cfg_k),
    .cfg_drain (cfg_drain),
    .busy      (busy),
    .done      (done),
    .ifm_req   (ifm_req),
    .en_i      (en_i),
    .clr_i     (clr_i),
    .en_w      (en_w),
    .clr_w     (clr_w),
    .en_o      (en_o),
    .clr_o     (clr_o),
    .mac_done  (mac_done),
    .dbg_state (dbg_state)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Issues start with (k,l,d) at the current negedge and checks every
  // following cycle. abort_at>0 asserts abort during that cycle number.
  task automatic run_tile(input string name, input int k, input int l, input int d,
                          input int abort_at, input bit noise);
    logic [9:0] exp_q[$];
    logic [9:0] exp_v;
    int ke, le, cyc, done_cyc, n_ifm, n_eno, n_macd, lat;
    ke = (k == 0) ? 1 : k;
    le = (l == 0) ? 32768 : l;
    lat = 2 + ke * (le + 1) + d;
    exp_q.push_back(V_WLOAD);
    for (int i = 0; i < ke; i++) begin
      exp_q.push_back(V_IF);
      for (int j = 0; j < le; j++) begin
        exp_q.push_back(V_MAC | ((i == ke - 1 && j == le - 1) ? 10'd1 : 10'd0));
      end
    end
    for (int i = 0; i < d; i++) exp_q.push_back(V_DRAIN);
    exp_q.push_back(V_DONE);
    if (abort_at > 0) begin
      while (exp_q.size() > abort_at) void'(exp_q.pop_back());
      exp_q.push_back(V_CLR);
    end
    exp_q.push_back(V_IDLE);

    start     = 1'b1;
    abort     = 1'b0;
    cfg_mac   = 15'(l);
    cfg_k     = 16'(k);
    cfg_drain = 8'(d);
    cyc = 0; done_cyc = -1; n_ifm = 0; n_eno = 0; n_macd = 0;
    while (exp_q.size() > 0) begin
      @(negedge clk);
      cyc++;
      start = 1'b0;
      abort = (cyc == abort_at);
      if (noise && exp_q.size() > 1) begin
        start     = 1'($urandom_range(0, 1));
        cfg_mac   = 15'($urandom);
        cfg_k     = 16'($urandom);
        cfg_drain = 8'($urandom);
      end
      exp_v = exp_q.pop_front();
      n_tests++;
      if (obs !== exp_v) begin
        n_fail++;
        $display("FAIL %s trace cycle %0d: got %b expected %b", name, cyc, obs, exp_v);
      end
      if (ifm_req === 1'b1) n_ifm++;
      if (en_o === 1'b1) n_eno++;
      if (mac_done === 1'b1) n_macd++;
      if (done === 1'b1 && done_cyc < 0) done_cyc = cyc;
    end
    start = 1'b0;
    abort = 1'b0;

    n_tests++;
    if (abort_at > 0) begin
      if (done_cyc !== -1) begin
        n_fail++;
        $display("FAIL %s done_after_abort: done seen at cycle %0d, expected never", name, done_cyc);
      end
    end else begin
      if (done_cyc !== lat) begin
        n_fail++;
        $display("FAIL %s latency: done at cycle %0d expected %0d", name, done_cyc, lat);
      end
      n_tests += 3;
      if (n_ifm !== ke) begin
        n_fail++;
        $display("FAIL %s ifm_req_count: got %0d expected %0d", name, n_ifm, ke);
      end
      if (n_eno !== ke * le) begin
        n_fail++;
        $display("FAIL %s en_o_count: got %0d expected %0d", name, n_eno, ke * le);
      end
      if (n_macd !== 1) begin
        n_fail++;
        $display("FAIL %s mac_done_count: got %0d expected 1", name, n_macd);
      end
    end
  endtask

  task automatic test_reset();
    rst_n = 1'b0; start = 1'b0; abort = 1'b0;
    cfg_mac = '0; cfg_k = '0; cfg_drain = '0;
    #3;
    n_tests++;
    if (obs !== V_IDLE) begin
      n_fail++;
      $display("FAIL reset_value: got %b expected %b", obs, V_IDLE);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (obs !== V_IDLE) begin
      n_fail++;
      $display("FAIL reset_release: got %b expected %b", obs, V_IDLE);
    end
  endtask

  task automatic test_idle_controls();
    start = 1'b1; abort = 1'b1;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      start = (i == 0);
      n_tests++;
      if (obs !== V_IDLE) begin
        n_fail++;
        $display("FAIL idle_start_abort cycle %0d: got %b expected %b", i, obs, V_IDLE);
      end
    end
    start = 1'b0; abort = 1'b0;
  endtask

  task automatic test_basic();
    run_tile("basic_k1_l4_d0", 1, 4, 0, 0, 1'b0);
    run_tile("drain_k3_l2_d5", 3, 2, 5, 0, 1'b0);
    run_tile("k0_as_one", 0, 3, 1, 0, 1'b0);
    run_tile("l1_k2", 2, 1, 2, 0, 1'b0);
  endtask

  task automatic test_long_mac();
    run_tile("mac_len_zero", 1, 0, 0, 0, 1'b0);
  endtask

  task automatic test_abort();
    run_tile("abort_2nd_mac", 3, 3, 2, 8, 1'b0);
    run_tile("abort_wload", 2, 2, 1, 1, 1'b0);
    run_tile("abort_drain", 1, 2, 4, 6, 1'b0);
  endtask

  task automatic test_busy_noise();
    run_tile("noise_k2_l3_d2", 2, 3, 2, 0, 1'b1);
    run_tile("noise_k4_l2_d0", 4, 2, 0, 0, 1'b1);
  endtask

  task automatic test_reset_mid();
    start = 1'b1; cfg_mac = 15'd5; cfg_k = 16'd2; cfg_drain = 8'd1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      start = 1'b0;
    end
    n_tests++;
    if (obs !== V_MAC) begin
      n_fail++;
      $display("FAIL reset_mid_pre: got %b expected %b", obs, V_MAC);
    end
    #2;
    rst_n = 1'b0;
    #1;
    n_tests++;
    if (obs !== V_IDLE) begin
      n_fail++;
      $display("FAIL reset_mid_async: got %b expected %b", obs, V_IDLE);
    end
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    n_tests++;
    if (obs !== V_IDLE) begin
      n_fail++;
      $display("FAIL reset_mid_after: got %b expected %b", obs, V_IDLE);
    end
    run_tile("after_reset", 2, 5, 1, 0, 1'b0);
  endtask

  task automatic test_random();
    int k, l, d, ab, lat;
    for (int t = 0; t < 25; t++) begin
      k = $urandom_range(0, 4);
      l = $urandom_range(1, 6);
      d = $urandom_range(0, 4);
      lat = 2 + ((k == 0) ? 1 : k) * (l + 1) + d;
      ab = ($urandom_range(0, 3) == 0) ? $urandom_range(1, lat - 1) : 0;
      run_tile("random", k, l, d, ab, 1'($urandom_range(0, 1)));
    end
  endtask

  initial begin
    n_tests = 0;
    n_fail  = 0;
    test_reset();
    test_idle_controls();
    test_basic();
    test_abort();
    test_busy_noise();
    test_reset_mid();
    test_random();
    test_long_mac();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
